pc_fetch_unit: RTL and testbench

- Owns the architectural program counter and runs instruction fetch for the multicycle core.
- Drives the current PC to the PC+2 incrementer and the instruction memory, and latches the returned word into the instruction register (IR).
- Commits the next PC on command from the control unit. Selectable sources: the incrementer result, the branch target, or the jump target.

---
 rtl/pc_fetch_unit_if.sv | 16 +
 rtl/pc_fetch_unit.sv | 135 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Instruction-memory read port between the fetch unit and imem.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if;
  logic        req;
  logic [15:0] addr;
  logic        ack;
  logic [15:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter and two-state instruction fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        fetch_en,
  input  wire logic        pc_write,
  input  wire logic [1:0]  next_sel,
  input  wire logic [15:0] pc_inc,
  input  wire logic [15:0] branch_target,
  input  wire logic [15:0] jump_target,
  output logic      [15:0] pc_out,
  output logic      [15:0] ir,
  output logic             ir_valid,
  output logic             busy,
  output logic             misalign,
  output logic             fetch_timeout,
  pc_fetch_unit_if.master  imem
);

  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        r_ir_valid;
  logic        r_req;
  logic        r_misalign;
  logic        r_timeout;
  logic [7:0]  r_cnt;
  logic        r_pend_valid;
  logic [15:0] r_pend_val;

  logic [15:0] w_sel_val;
  logic        w_sel_hold;
  logic        w_commit_en;
  logic [15:0] w_commit_val;

  always_comb begin
    w_sel_hold = (next_sel == 2'b11);
    unique case (next_sel)
      2'b00:   w_sel_val = pc_inc;
      2'b01:   w_sel_val = branch_target;
      2'b10:   w_sel_val = jump_target;
      default: w_sel_val = r_pc;
    endcase
  end

  // A fresh pc_write in IDLE supersedes any update deferred from the last fetch.
  always_comb begin
    w_commit_en  = r_pend_valid;
    w_commit_val = r_pend_val;
    if (pc_write) begin
      w_commit_en  = !w_sel_hold;
      w_commit_val = w_sel_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_ir         <= 16'h0000;
      r_ir_valid   <= 1'b0;
      r_req        <= 1'b0;
      r_misalign   <= 1'b0;
      r_timeout    <= 1'b0;
      r_cnt        <= 8'd0;
      r_pend_valid <= 1'b0;
      r_pend_val   <= 16'h0000;
    end else begin
      r_ir_valid <= 1'b0;
      r_timeout  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_pend_valid <= 1'b0;
          if (w_commit_en) begin
            if (w_commit_val[0]) begin
              r_misalign <= 1'b1;
            end else begin
              r_pc <= w_commit_val;
            end
          end
          if (fetch_en && !r_misalign) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_cnt   <= 8'd0;
          end
        end
        ST_REQ: begin
          // PC must stay put while the request is outstanding; defer the write.
          if (pc_write) begin
            r_pend_valid <= !w_sel_hold;
            r_pend_val   <= w_sel_val;
          end
          if (imem.ack) begin
            r_ir       <= imem.rdata;
            r_ir_valid <= 1'b1;
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
          end else if (r_cnt == c_timeout_last) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign pc_out        = r_pc;
  assign ir            = r_ir;
  assign ir_valid      = r_ir_valid;
  assign busy          = r_req;
  assign misalign      = r_misalign;
  assign fetch_timeout = r_timeout;
  assign imem.req      = r_req;
  assign imem.addr     = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        pc_write = 1'b0;
  logic [1:0]  next_sel = 2'b00;
  logic [15:0] pc_inc = 16'h0000;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] jump_target = 16'h0000;
  logic [15:0] pc_out;
  logic [15:0] ir;
  logic        ir_valid;
  logic        busy;
  logic        misalign;
  logic        fetch_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int n_req;

  pc_fetch_unit_if imem_bus ();

  pc_fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .pc_write      (pc_write),
    .next_sel      (next_sel),
    .pc_inc        (pc_inc),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .pc_out        (pc_out),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .busy          (busy),
    .misalign      (misalign),
    .fetch_timeout (fetch_timeout),
    .imem          (imem_bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 16'h0000;

    // reset state
    tick();
    tick();
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_req", imem_bus.req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_irv", ir_valid, 1'b0);
    chk("rst_to", fetch_timeout, 1'b0);
    rst_n = 1'b1;
    tick();

    // zero-wait fetch at RESET_PC
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("f1_req", imem_bus.req, 1'b1);
    chk("f1_busy", busy, 1'b1);
    chk("f1_addr", imem_bus.addr, 16'h0000);
    chk("f1_irv_early", ir_valid, 1'b0);
    imem_bus.ack = 1'b1; imem_bus.rdata = 16'h1234;
    tick();
    imem_bus.ack = 1'b0;
    chk("f1_ir", ir, 16'h1234);
    chk("f1_irv", ir_valid, 1'b1);
    chk("f1_req_drop", imem_bus.req, 1'b0);
    tick();
    chk("f1_irv_pulse", ir_valid, 1'b0);

    // sequential step
    pc_write = 1'b1; next_sel = 2'b00; pc_inc = 16'h0002;
    tick();
    pc_write = 1'b0;
    chk("seq_pc", pc_out, 16'h0002);

    // branch captured while the fetch waits for ack
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("br_addr", imem_bus.addr, 16'h0002);
    pc_write = 1'b1; next_sel = 2'b01; branch_target = 16'h0040;
    tick();
    pc_write = 1'b0;
    chk("br_hold1", pc_out, 16'h0002);
    tick();
    chk("br_hold2", pc_out, 16'h0002);
    imem_bus.ack = 1'b1; imem_bus.rdata = 16'hABCD;
    tick();
    imem_bus.ack = 1'b0;
    chk("br_ir", ir, 16'hABCD);
    chk("br_pc_at_ack", pc_out, 16'h0002);
    // fetch issued on the cycle the deferred branch commits
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("br_pc_applied", pc_out, 16'h0040);
    chk("br_refetch_addr", imem_bus.addr, 16'h0040);
    chk("br_refetch_req", imem_bus.req, 1'b1);
    imem_bus.ack = 1'b1; imem_bus.rdata = 16'h5555;
    tick();
    imem_bus.ack = 1'b0;
    chk("br_refetch_ir", ir, 16'h5555);

    // wrap of the incrementer
    pc_write = 1'b1; next_sel = 2'b10; jump_target = 16'hFFFE;
    tick();
    chk("wrap_pre", pc_out, 16'hFFFE);
    next_sel = 2'b00; pc_inc = 16'h0000;
    tick();
    pc_write = 1'b0;
    chk("wrap_pc", pc_out, 16'h0000);

    // simultaneous pc_write and fetch_en in IDLE
    pc_write = 1'b1; fetch_en = 1'b1; next_sel = 2'b01; branch_target = 16'h0080;
    tick();
    pc_write = 1'b0; fetch_en = 1'b0;
    chk("sim_addr", imem_bus.addr, 16'h0080);
    chk("sim_req", imem_bus.req, 1'b1);
    imem_bus.ack = 1'b1; imem_bus.rdata = 16'h7777;
    tick();
    imem_bus.ack = 1'b0;

    // hold select ignores an odd source
    pc_write = 1'b1; next_sel = 2'b11; branch_target = 16'h0011;
    tick();
    pc_write = 1'b0;
    chk("hold_pc", pc_out, 16'h0080);
    chk("hold_misalign", misalign, 1'b0);

    // timeout with no ack
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    n_req = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!imem_bus.req) break;
      n_req++;
    end
    chk("to_req_cycles", n_req, 16);
    chk("to_pulse", fetch_timeout, 1'b1);
    chk("to_req_low", imem_bus.req, 1'b0);
    chk("to_ir_kept", ir, 16'h7777);
    tick();
    chk("to_pulse_end", fetch_timeout, 1'b0);

    // misaligned jump
    pc_write = 1'b1; next_sel = 2'b10; jump_target = 16'h0031;
    tick();
    pc_write = 1'b0;
    chk("mis_pc", pc_out, 16'h0080);
    chk("mis_flag", misalign, 1'b1);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("mis_no_req", imem_bus.req, 1'b0);
    tick();
    chk("mis_sticky", misalign, 1'b1);

    // reset in the middle of a fetch
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pc_write = 1'b1; next_sel = 2'b10; jump_target = 16'h0100;
    tick();
    pc_write = 1'b0;
    chk("mr_pc_set", pc_out, 16'h0100);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("mr_req", imem_bus.req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_req_async", imem_bus.req, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_pc", pc_out, 16'h0000);
    imem_bus.ack = 1'b1; imem_bus.rdata = 16'h9999;
    tick();
    imem_bus.ack = 1'b0;
    chk("mr_no_irv", ir_valid, 1'b0);
    chk("mr_ir", ir, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
